kbd_event_scheduler: RTL and testbench

//  Sits between the PS/2 byte receiver and game logic. Decodes raw scan-code bytes
//  (set 2: E0 extended prefix, F0 break prefix) into press/release events for eight

---
 rtl/kbd_event_scheduler_pkg.sv | 72 +++++++
 rtl/kbd_event_scheduler_if.sv | 22 ++
 rtl/kbd_event_scheduler_fifo.sv | 63 ++++++
 rtl/kbd_event_scheduler.sv | 159 +++++++++++++++
 tb/tb_kbd_event_scheduler.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/kbd_event_scheduler_pkg.sv
// Shared scan-code constants, key indices, decoder state encodings and
// helpers for the keyboard event scheduler.
package kbd_event_scheduler_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;

    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_Z     = 8'h1A;
    localparam logic [7:0] SC_X     = 8'h22;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_ESC   = 8'h76;

    localparam logic [2:0] KEY_UP    = 3'd0;
    localparam logic [2:0] KEY_DOWN  = 3'd1;
    localparam logic [2:0] KEY_LEFT  = 3'd2;
    localparam logic [2:0] KEY_RIGHT = 3'd3;
    localparam logic [2:0] KEY_Z     = 3'd4;
    localparam logic [2:0] KEY_X     = 3'd5;
    localparam logic [2:0] KEY_ENTER = 3'd6;
    localparam logic [2:0] KEY_ESC   = 3'd7;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXT     = 2'd1;
    localparam logic [1:0] ST_BRK     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    typedef struct packed {
        logic       press;
        logic [2:0] key;
    } kbd_event_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] key;
    } key_match_t;

    // The extended flag is part of the match: plain 75 is keypad 8, not UP.
    function automatic key_match_t key_lookup(input logic [7:0] code, input logic ext);
        key_match_t m;
        m.hit = 1'b1;
        m.key = KEY_UP;
        if (ext) begin
            case (code)
                SC_UP:    m.key = KEY_UP;
                SC_DOWN:  m.key = KEY_DOWN;
                SC_LEFT:  m.key = KEY_LEFT;
                SC_RIGHT: m.key = KEY_RIGHT;
                default:  m.hit = 1'b0;
            endcase
        end else begin
            case (code)
                SC_Z:     m.key = KEY_Z;
                SC_X:     m.key = KEY_X;
                SC_ENTER: m.key = KEY_ENTER;
                SC_ESC:   m.key = KEY_ESC;
                default:  m.hit = 1'b0;
            endcase
        end
        return m;
    endfunction

    // Keyboard status/ack bytes that never participate in decoding.
    function automatic logic is_ignored(input logic [7:0] code);
        return (code == 8'hAA) || (code == 8'hFA) || (code == 8'hFE) ||
               (code == 8'hEE) || (code == 8'h00) || (code == 8'hFF);
    endfunction

endpackage

// File: rtl/kbd_event_scheduler_if.sv
// Byte-in / event-out bundle between the PS/2 receiver, the scheduler and
// the game FSM. The scheduler is the slave side.
interface kbd_event_scheduler_if;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       ev_ready;
    logic       ev_valid;
    logic       ev_press;
    logic [2:0] ev_key;
    logic [7:0] key_held;
    logic       ovf;

    modport master (
        output rx_byte, rx_valid, ev_ready,
        input  ev_valid, ev_press, ev_key, key_held, ovf
    );

    modport slave (
        input  rx_byte, rx_valid, ev_ready,
        output ev_valid, ev_press, ev_key, key_held, ovf
    );
endinterface

// File: rtl/kbd_event_scheduler_fifo.sv
// First-word-fall-through event FIFO. A push into a full FIFO is dropped
// unless a pop happens in the same cycle; a drop raises a 1-cycle ovf pulse.
module kbd_event_scheduler_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             ovf_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             ovf_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // When full, a simultaneous pop frees the slot the write lands in.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            ovf_q <= push_i && !do_push;
        end
    end

    assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/kbd_event_scheduler.sv
// Scan-code set 2 decoder: prefix FSM with timeout, key map, held-key bitmap
// with typematic suppression, and an event FIFO drained via valid/ready.
//
//  state      | meaning
//  -----------+-----------------------------------------------
//  ST_IDLE    | no prefix pending
//  ST_EXT     | E0 seen, waiting for code or F0
//  ST_BRK     | F0 seen, next code is a plain break
//  ST_EXT_BRK | E0 F0 seen, next code is an extended break
module kbd_event_scheduler #(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    kbd_event_scheduler_if.slave kbd_if
);
    import kbd_event_scheduler_pkg::*;

    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [1:0]    rst_sync_q;
    logic          rst_core_n;
    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [TW-1:0] tmo_q;
    logic [TW-1:0] tmo_d;
    logic [7:0]    held_q;
    logic [7:0]    held_d;
    logic          is_make;
    logic          is_break;
    logic          ext_sel;
    key_match_t    match;
    logic          push;
    kbd_event_t    push_ev;
    kbd_event_t    head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_ovf;

    // Reset asserts immediately, releases two clocks after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_core_n = rst_sync_q[1];

    always_comb begin
        state_d  = state_q;
        tmo_d    = tmo_q;
        is_make  = 1'b0;
        is_break = 1'b0;
        ext_sel  = 1'b0;
        if (kbd_if.rx_valid) begin
            tmo_d = '0;
            if (!is_ignored(kbd_if.rx_byte)) begin
                case (state_q)
                    ST_IDLE: begin
                        if (kbd_if.rx_byte == SC_EXT) begin
                            state_d = ST_EXT;
                        end else if (kbd_if.rx_byte == SC_BRK) begin
                            state_d = ST_BRK;
                        end else begin
                            is_make = 1'b1;
                        end
                    end
                    ST_EXT: begin
                        if (kbd_if.rx_byte == SC_BRK) begin
                            state_d = ST_EXT_BRK;
                        end else if (kbd_if.rx_byte != SC_EXT) begin
                            is_make = 1'b1;
                            ext_sel = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                    ST_BRK: begin
                        state_d  = ST_IDLE;
                        is_break = (kbd_if.rx_byte != SC_EXT) && (kbd_if.rx_byte != SC_BRK);
                    end
                    ST_EXT_BRK: begin
                        state_d  = ST_IDLE;
                        ext_sel  = 1'b1;
                        is_break = (kbd_if.rx_byte != SC_EXT) && (kbd_if.rx_byte != SC_BRK);
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end else if (state_q != ST_IDLE) begin
            if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                state_d = ST_IDLE;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    assign match = key_lookup(kbd_if.rx_byte, ext_sel);

    // Repeated makes and stray breaks leave the bitmap alone and push nothing.
    always_comb begin
        held_d  = held_q;
        push    = 1'b0;
        push_ev = '0;
        if (match.hit) begin
            if (is_make && !held_q[match.key]) begin
                held_d[match.key] = 1'b1;
                push              = 1'b1;
                push_ev.press     = 1'b1;
                push_ev.key       = match.key;
            end else if (is_break && held_q[match.key]) begin
                held_d[match.key] = 1'b0;
                push              = 1'b1;
                push_ev.press     = 1'b0;
                push_ev.key       = match.key;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_core_n) begin
        if (!rst_core_n) begin
            state_q <= ST_IDLE;
            tmo_q   <= '0;
            held_q  <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            held_q  <= held_d;
        end
    end

    kbd_event_scheduler_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (4)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_core_n),
        .push_i      (push),
        .push_data_i (push_ev),
        .pop_i       (kbd_if.ev_ready),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .ovf_o       (fifo_ovf)
    );

    a_fifo_state: assert property (@(posedge clk) disable iff (!rst_core_n)
        !(fifo_full && fifo_empty));

    assign kbd_if.ev_valid = !fifo_empty;
    assign kbd_if.ev_press = head.press;
    assign kbd_if.ev_key   = head.key;
    assign kbd_if.key_held = held_q;
    assign kbd_if.ovf      = fifo_ovf;

endmodule

// File: tb/tb_kbd_event_scheduler.sv
// Scoreboard bench: a prefix/bitmap reference model predicts events into a
// queue; a monitor pops and compares whenever the DUT hands an event over.
module tb_kbd_event_scheduler;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    kbd_event_scheduler_if kif ();

    kbd_event_scheduler #(
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .kbd_if (kif)
    );

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    bit [3:0] exp_q [$];
    bit [7:0] m_held;
    bit       m_ext;
    bit       m_brk;
    time      last_t;
    bit       in_reset = 1'b1;
    int       ready_mode = 0;

    logic [7:0] kcode [8] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h1A, 8'h22, 8'h5A, 8'h76};
    bit         kext  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [7:0] pool  [18] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h1A, 8'h22, 8'h5A, 8'h76,
                               8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'hAA, 8'hFA, 8'h00,
                               8'h1C, 8'h29, 8'hFF};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_ready();
        case (ready_mode)
            0: kif.ev_ready = 1'b0;
            1: kif.ev_ready = 1'b1;
            2: kif.ev_ready = 1'($urandom_range(0, 1));
            default: begin
                kif.ev_ready = 1'b1;
                ready_mode   = 0;
            end
        endcase
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_held = '0;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
    endtask

    task automatic model_push(input bit press, input int idx, output bit drop);
        if (exp_q.size() >= DEPTH) begin
            drop = 1'b1;
        end else begin
            exp_q.push_back({press, 3'(idx)});
        end
    endtask

    // Called at the sampling edge; exp_q already reflects this edge's pop.
    task automatic model_byte(input logic [7:0] b, output bit drop);
        int gap;
        int idx;
        drop   = 1'b0;
        gap    = int'(($time - last_t) / 10) - 1;
        last_t = $time;
        if ((m_ext || m_brk) && gap >= TMO) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
        if (b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hEE || b == 8'h00 || b == 8'hFF)
            return;
        if (b == 8'hE0) begin
            if (m_brk) begin m_ext = 1'b0; m_brk = 1'b0; end
            else m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            if (m_brk) begin m_ext = 1'b0; m_brk = 1'b0; end
            else m_brk = 1'b1;
        end else begin
            idx = -1;
            for (int k = 0; k < 8; k++)
                if (kcode[k] == b && kext[k] == m_ext) idx = k;
            if (idx >= 0) begin
                if (!m_brk && !m_held[idx]) begin
                    m_held[idx] = 1'b1;
                    model_push(1'b1, idx, drop);
                end else if (m_brk && m_held[idx]) begin
                    m_held[idx] = 1'b0;
                    model_push(1'b0, idx, drop);
                end
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit drop;
        @(negedge clk);
        kif.rx_byte  = b;
        kif.rx_valid = 1'b1;
        set_ready();
        @(posedge clk);
        model_byte(b, drop);
        #1;
        check("key_held", int'(kif.key_held), int'(m_held));
        check("ovf", int'(kif.ovf), int'(drop));
        @(negedge clk);
        kif.rx_valid = 1'b0;
        set_ready();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            kif.rx_valid = 1'b0;
            set_ready();
        end
    endtask

    task automatic drain();
        int budget;
        ready_mode = 1;
        budget     = 0;
        while ((exp_q.size() != 0 || kif.ev_valid) && budget < 100) begin
            idle(1);
            budget++;
        end
        idle(1);
        check("drain_empty", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        bit [3:0] e;
        #1;
        if (!in_reset) begin
            check("ev_valid", int'(kif.ev_valid), int'(exp_q.size() != 0));
            if (kif.ev_valid && kif.ev_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                pops++;
                check("event", int'({kif.ev_press, kif.ev_key}), int'(e));
            end else if (!kif.ev_valid) begin
                check("idle_head", int'({kif.ev_press, kif.ev_key}), 0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        kif.rx_byte  = '0;
        kif.rx_valid = 1'b0;
        kif.ev_ready = 1'b0;
        model_clear();
        last_t = 0;

        idle(2);
        check("rst_ev_valid", int'(kif.ev_valid), 0);
        check("rst_key_held", int'(kif.key_held), 0);
        check("rst_ovf", int'(kif.ovf), 0);
        rst_n = 1'b1;
        idle(3);
        in_reset = 1'b0;

        // press / release Z
        ready_mode = 1;
        p0 = pops;
        send_byte(8'h1A);
        check("t1_held_press", int'(kif.key_held), 8'h10);
        send_byte(8'hF0);
        send_byte(8'h1A);
        check("t1_held_rel", int'(kif.key_held), 0);
        drain();
        check("t1_events", pops - p0, 2);

        // typematic UP
        p0 = pops;
        repeat (5) begin
            send_byte(8'hE0);
            send_byte(8'h75);
        end
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        drain();
        check("t2_events", pops - p0, 2);

        // keypad 8 is not UP
        p0 = pops;
        send_byte(8'h75);
        send_byte(8'hF0);
        send_byte(8'h75);
        check("t3_held", int'(kif.key_held), 0);
        drain();
        check("t3_events", pops - p0, 0);

        // overflow, then push+pop while full
        ready_mode = 0;
        idle(2);
        send_byte(8'h1A);
        send_byte(8'h22);
        send_byte(8'h5A);
        send_byte(8'h76);
        send_byte(8'hE0);
        send_byte(8'h75);
        check("t4_held", int'(kif.key_held), 8'hF1);
        send_byte(8'hE0);
        ready_mode = 3;
        send_byte(8'h72);
        check("t4_full_valid", int'(kif.ev_valid), 1);
        send_byte(8'hF0);
        send_byte(8'h1A);
        p0 = pops;
        drain();
        check("t4_drained", pops - p0, 4);
        send_byte(8'hF0); send_byte(8'h22);
        send_byte(8'hF0); send_byte(8'h5A);
        send_byte(8'hF0); send_byte(8'h76);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h72);
        drain();
        check("t4_held_clear", int'(kif.key_held), 0);

        // prefix timeout and its boundary
        send_byte(8'hE0);
        idle(15);
        send_byte(8'h74);
        check("t5_aborted", int'(kif.key_held[3]), 0);
        send_byte(8'hE0);
        idle(14);
        send_byte(8'h74);
        check("t5_in_time", int'(kif.key_held[3]), 1);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
        drain();

        // asynchronous reset mid-sequence
        ready_mode = 0;
        idle(1);
        send_byte(8'h1A);
        send_byte(8'h22);
        send_byte(8'hF0);
        #3;
        in_reset = 1'b1;
        rst_n    = 1'b0;
        #1;
        check("t6_ev_valid", int'(kif.ev_valid), 0);
        check("t6_key_held", int'(kif.key_held), 0);
        check("t6_head", int'({kif.ev_press, kif.ev_key}), 0);
        check("t6_ovf", int'(kif.ovf), 0);
        model_clear();
        idle(2);
        rst_n = 1'b1;
        idle(3);
        in_reset = 1'b0;
        ready_mode = 1;
        p0 = pops;
        send_byte(8'h5A);
        check("t6_held_after", int'(kif.key_held), 8'h40);
        drain();
        check("t6_events", pops - p0, 1);

        // randomized traffic
        ready_mode = 2;
        for (int i = 0; i < 400; i++) begin
            send_byte(pool[$urandom_range(0, 17)]);
            if ($urandom_range(0, 19) == 0) idle($urandom_range(13, 17));
            else idle($urandom_range(0, 2));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
